// File: rtl/shiftrows_stream.sv
// shiftrows_stream: ping-pong byte-stream AES ShiftRows / InvShiftRows permuter (Rijndael NB columns).
// Optional macro SHIFTROWS_INV_EN builds the inverse path selected by in_inv; otherwise forward only.

module shiftrows_bank #(
  parameter int L  = 16,
  parameter int CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          wr_last,
  input  logic [CW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  input  logic          rd_last,
  input  logic [CW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          full
);
  typedef enum logic [1:0] {FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e   st, st_nxt;
  logic [7:0] mem [L];

  // Storage is intentionally not reset; the state machine decides what is live.
  always_ff @(posedge clock)
    if (wr_en) mem[wr_addr] <= wr_data;

  assign rd_data = mem[rd_addr];

  always_ff @(posedge clock)
    if (reset) st <= FILLING;
    else       st <= st_nxt;

  always_comb begin
    st_nxt = st;
    case (st)
      FILLING:  if (wr_en && wr_last) st_nxt = FULL;
      FULL:     if (rd_en)            st_nxt = DRAINING;
      DRAINING: if (rd_en && rd_last) st_nxt = FILLING;
      default:                        st_nxt = FILLING;
    endcase
  end

  assign full = (st != FILLING);
endmodule

module shiftrows_stream #(
  parameter int NB = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_inv,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_first,
  output logic       out_inv
);
  localparam int            L    = 4 * NB;
  localparam int            CW   = $clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  logic          wr_sel, rd_sel;
  logic [CW-1:0] wr_cnt, rd_cnt, rd_addr;
  logic          acc, emit, wr_last, rd_last;
  logic [1:0]    full, wr_en, rd_en;
  logic [1:0][7:0] rd_data;

  // Rijndael row shift: NB=8 skips offset 2 for rows 2 and 3.
  function automatic int row_off(input int r);
    return (NB == 8 && r >= 2) ? r + 1 : r;
  endfunction

  function automatic logic [CW-1:0] fwd_idx(input logic [CW-1:0] i);
    int r, c;
    r = int'(i) % 4;
    c = int'(i) / 4 + row_off(r);
    if (c >= NB) c = c - NB;
    return CW'(r + 4 * c);
  endfunction

  assign in_ready  = !full[wr_sel];
  assign acc       = in_valid && in_ready;
  assign out_valid = full[rd_sel];
  assign emit      = out_valid && out_ready;
  assign wr_last   = (wr_cnt == LAST);
  assign rd_last   = (rd_cnt == LAST);
  assign wr_en     = {acc & wr_sel, acc & ~wr_sel};
  assign rd_en     = {emit & rd_sel, emit & ~rd_sel};

  always_ff @(posedge clock)
    if (reset) begin
      wr_cnt <= '0;
      wr_sel <= 1'b0;
    end else if (acc) begin
      wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
      if (wr_last) wr_sel <= ~wr_sel;
    end

  always_ff @(posedge clock)
    if (reset) begin
      rd_cnt <= '0;
      rd_sel <= 1'b0;
    end else if (emit) begin
      rd_cnt <= rd_last ? '0 : rd_cnt + 1'b1;
      if (rd_last) rd_sel <= ~rd_sel;
    end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    shiftrows_bank #(.L(L), .CW(CW)) u_bank (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en[b]),
      .wr_last (wr_last),
      .wr_addr (wr_cnt),
      .wr_data (in_byte),
      .rd_en   (rd_en[b]),
      .rd_last (rd_last),
      .rd_addr (rd_addr),
      .rd_data (rd_data[b]),
      .full    (full[b])
    );
  end

`ifdef SHIFTROWS_INV_EN
  logic [1:0] mode;

  function automatic logic [CW-1:0] inv_idx(input logic [CW-1:0] i);
    int r, c;
    r = int'(i) % 4;
    c = int'(i) / 4 + NB - row_off(r);
    if (c >= NB) c = c - NB;
    return CW'(r + 4 * c);
  endfunction

  // Mode is captured only with byte 0; later in_inv wiggles cannot touch the block.
  always_ff @(posedge clock)
    if (reset)                     mode <= '0;
    else if (acc && wr_cnt == '0)  mode[wr_sel] <= in_inv;

  assign out_inv = out_valid & mode[rd_sel];
  assign rd_addr = mode[rd_sel] ? inv_idx(rd_cnt) : fwd_idx(rd_cnt);
`else
  logic unused_inv;
  assign unused_inv = in_inv;
  assign out_inv    = 1'b0;
  assign rd_addr    = fwd_idx(rd_cnt);
`endif

  assign out_byte  = out_valid ? rd_data[rd_sel] : 8'h00;
  assign out_first = out_valid && (rd_cnt == '0);
endmodule

// File: tb/tb_shiftrows_stream.sv
// Bench for shiftrows_stream: queue-based block model checked every cycle plus FIPS-197 / hand-derived literals.
module tb_shiftrows_stream;
  logic       clock = 0;
  logic       reset;
  logic [7:0] in_byte;
  logic       in_valid, in_inv, out_ready;
  logic       in_ready, out_valid, out_first, out_inv;
  logic [7:0] out_byte;

  logic [7:0] in_byte8;
  logic       in_valid8, in_inv8, out_ready8;
  logic       in_ready8, out_valid8, out_first8, out_inv8;
  logic [7:0] out_byte8;

  always #5 clock = ~clock;

  shiftrows_stream #(.NB(4)) dut (
    .clock(clock), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_inv(out_inv));

  shiftrows_stream #(.NB(8)) dut8 (
    .clock(clock), .reset(reset), .in_byte(in_byte8), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_inv(in_inv8), .out_byte(out_byte8), .out_valid(out_valid8), .out_ready(out_ready8),
    .out_first(out_first8), .out_inv(out_inv8));

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // out(r,c) = in(r, (c +/- C_r) mod nb), written straight from the row-offset rule.
  function automatic logic [7:0] model_byte(input logic [7:0] blk [32], input int nb, input bit inv, input int i);
    int r, c, sh, sc;
    r  = i % 4;
    c  = i / 4;
    sh = (nb == 8) ? ((r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? 3 : 4) : r;
    sc = inv ? (c - sh + nb) % nb : (c + sh) % nb;
    return blk[r + 4 * sc];
  endfunction

  typedef struct packed {logic [7:0] b; logic first; logic inv;} exp_t;
  exp_t       q[$];
  logic [7:0] part [32];
  int         pcnt = 0;
  bit         pinv;
  logic [7:0] log_b[$];
  int         emit_cyc[$], blk_done[$];
  int         ready_low = 0;
  bit         stall_en = 0;

  always @(posedge clock) cyc++;

  // Single compare process: DUT outputs vs. model on every cycle out of reset.
  always @(negedge clock) begin
    int nfull;
    if (reset) begin
      q.delete();
      pcnt = 0;
    end else begin
      nfull = (q.size() + 15) / 16;
      chk("in_ready", 32'(in_ready), 32'(nfull < 2));
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (!in_ready) ready_low++;
      if (out_valid && q.size() > 0) begin
        chk("out_byte", 32'(out_byte), 32'(q[0].b));
        chk("out_first", 32'(out_first), 32'(q[0].first));
        chk("out_inv", 32'(out_inv), 32'(q[0].inv));
        if (out_ready) begin
          log_b.push_back(out_byte);
          emit_cyc.push_back(cyc);
          void'(q.pop_front());
        end
      end else if (!out_valid) begin
        chk("idle_byte", 32'(out_byte), 32'h0);
        chk("idle_first", 32'(out_first), 32'h0);
        chk("idle_inv", 32'(out_inv), 32'h0);
      end
      if (in_valid && in_ready) begin
`ifdef SHIFTROWS_INV_EN
        if (pcnt == 0) pinv = in_inv;
`else
        if (pcnt == 0) pinv = 0;
`endif
        part[pcnt] = in_byte;
        pcnt++;
        if (pcnt == 16) begin
          for (int i = 0; i < 16; i++) q.push_back({model_byte(part, 4, pinv, i), i == 0, pinv});
          blk_done.push_back(cyc);
          pcnt = 0;
        end
      end
    end
  end

  logic [7:0] log8[$];
  logic       first8[$];
  always @(negedge clock)
    if (!reset && out_valid8 && out_ready8) begin
      log8.push_back(out_byte8);
      first8.push_back(out_first8);
    end

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clock); #1;
      out_ready = stall_en ? ($urandom_range(0, 3) == 0) : 1'b1;
    end
  end

  task automatic push_byte(input logic [7:0] b, input logic inv);
    int n = 0;
    in_valid = 1; in_byte = b; in_inv = inv;
    forever begin
      @(negedge clock);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        chk("push_timeout", 32'(n), 32'h0);
        break;
      end
    end
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic send_block(input logic [7:0] blk [16], input bit inv);
    for (int k = 0; k < 16; k++) push_byte(blk[k], (k == 0) ? inv : 1'($urandom));
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((q.size() != 0 || pcnt != 0) && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, "_drain_in_time"}, 32'(n < 2000), 32'h1);
  endtask

  logic [7:0] fips_in  [16] = '{8'hd4,8'h27,8'h11,8'hae,8'he0,8'hbf,8'h98,8'hf1,8'hb8,8'hb4,8'h5d,8'he5,8'h1e,8'h41,8'h52,8'h30};
  logic [7:0] fips_out [16] = '{8'hd4,8'hbf,8'h5d,8'h30,8'he0,8'hb4,8'h52,8'hae,8'hb8,8'h41,8'h11,8'hf1,8'h1e,8'h27,8'h98,8'he5};
  logic [7:0] inv_out  [16] = '{8'h00,8'h0d,8'h0a,8'h07,8'h04,8'h01,8'h0e,8'h0b,8'h08,8'h05,8'h02,8'h0f,8'h0c,8'h09,8'h06,8'h03};
  logic [7:0] fwd_out  [16] = '{8'h00,8'h05,8'h0a,8'h0f,8'h04,8'h09,8'h0e,8'h03,8'h08,8'h0d,8'h02,8'h07,8'h0c,8'h01,8'h06,8'h0b};
  logic [7:0] col8     [4]  = '{8'h00,8'h05,8'h0e,8'h13};

  initial begin
    logic [7:0] seq [16];
    logic [7:0] rnd [16];
    logic [7:0] blk8 [32];
    int base, dbase, n;
    for (int i = 0; i < 16; i++) seq[i] = 8'(i);
    reset = 1; in_valid = 0; in_byte = 0; in_inv = 0;
    in_valid8 = 0; in_byte8 = 0; in_inv8 = 0; out_ready8 = 1;
    repeat (3) @(posedge clock);
    #1 reset = 0;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_byte", 32'(out_byte), 32'h0);
    chk("rst_out_first", 32'(out_first), 32'h0);
    chk("rst_out_inv", 32'(out_inv), 32'h0);
    @(posedge clock); #1;

    base = log_b.size();
    send_block(fips_in, 0);
    wait_drain("fips");
    for (int i = 0; i < 16; i++) chk($sformatf("fips_lit[%0d]", i), 32'(log_b[base + i]), 32'(fips_out[i]));

    base = log_b.size();
    send_block(seq, 1);
    wait_drain("inv");
    for (int i = 0; i < 16; i++)
`ifdef SHIFTROWS_INV_EN
      chk($sformatf("inv_lit[%0d]", i), 32'(log_b[base + i]), 32'(inv_out[i]));
`else
      chk($sformatf("fwdonly_lit[%0d]", i), 32'(log_b[base + i]), 32'(fwd_out[i]));
`endif

    base = emit_cyc.size();
    dbase = blk_done.size();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom);
      send_block(rnd, 1'($urandom));
    end
    wait_drain("b2b");
    chk("b2b_count", 32'(emit_cyc.size() - base), 32'd48);
    chk("b2b_no_gap", 32'(emit_cyc[base + 47] - emit_cyc[base]), 32'd47);
    chk("b2b_latency", 32'(emit_cyc[base]), 32'(blk_done[dbase] + 1));

    stall_en = 1;
    ready_low = 0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom);
      send_block(rnd, 1'($urandom));
    end
    stall_en = 0;
    wait_drain("stall");
    chk("stall_backpressure_seen", 32'(ready_low > 0), 32'h1);

    for (int i = 0; i < 7; i++) push_byte(8'hf0 + 8'(i), 0);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    @(negedge clock);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    @(posedge clock); #1;
    base = log_b.size();
    send_block(seq, 0);
    wait_drain("midrst");
    for (int i = 0; i < 16; i++) chk($sformatf("midrst_lit[%0d]", i), 32'(log_b[base + i]), 32'(fwd_out[i]));

    for (int i = 0; i < 32; i++) blk8[i] = 8'(i);
    in_valid8 = 1;
    for (int i = 0; i < 32; i++) begin
      in_byte8 = 8'(i);
      @(negedge clock);
      chk("nb8_in_ready", 32'(in_ready8), 32'h1);
      @(posedge clock); #1;
    end
    in_valid8 = 0;
    n = 0;
    while (log8.size() < 32 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("nb8_count", 32'(log8.size()), 32'd32);
    if (log8.size() >= 32) begin
      for (int i = 0; i < 4; i++) chk($sformatf("nb8_col0[%0d]", i), 32'(log8[i]), 32'(col8[i]));
      for (int i = 0; i < 32; i++) chk($sformatf("nb8_byte[%0d]", i), 32'(log8[i]), 32'(model_byte(blk8, 8, 0, i)));
      chk("nb8_first0", 32'(first8[0]), 32'h1);
      chk("nb8_first1", 32'(first8[1]), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shiftrows_stream.md
SHIFTROWS_STREAM -- requirements
Module: shiftrows_stream

Interface
REQ-001 Parameter NB, default 4, meaning Rijndael block columns; legal values 4, 6, 8; block length L = 4*NB bytes.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 in_byte  input  8  state byte in column-major order, index i = r + 4*c.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  block accepts a byte this cycle.
REQ-007 in_inv  input  1  1 = InvShiftRows, 0 = ShiftRows; sampled with byte 0 of each block only.
REQ-008 out_byte  output  8  permuted state byte, column-major order.
REQ-009 out_valid  output  1  out_byte is valid this cycle.
REQ-010 out_ready  input  1  sink accepts out_byte this cycle.
REQ-011 out_first  output  1  high with output byte index 0 of each block.
REQ-012 out_inv  output  1  mode latched for the block being emitted.

Function
REQ-013 Row offsets C_r SHALL be 0,1,2,3 for NB=4 or 6 and 0,1,3,4 for NB=8.
REQ-014 Forward: output byte (r,c) SHALL equal input byte (r, (c+C_r) mod NB); inverse: input byte (r, (c-C_r) mod NB).
REQ-015 Two L-byte banks (ping-pong), each with full flag and latched mode bit; write select wr_sel, read select rd_sel, counters wr_cnt and rd_cnt in 0..L-1.
REQ-016 Write FSM per bank: FILLING -> FULL -> DRAINING -> FILLING; in_ready = !full[wr_sel], combinational from registered state.
REQ-017 A byte is accepted when in_valid && in_ready; it is stored at bank[wr_sel][wr_cnt] and wr_cnt increments.
REQ-018 On acceptance with wr_cnt == L-1: full[wr_sel] set, wr_cnt wraps to 0, wr_sel toggles.
REQ-019 out_valid = full[rd_sel]; out_byte = bank[rd_sel][src(rd_cnt, mode)] when out_valid, else 8'h00.
REQ-020 A byte is emitted when out_valid && out_ready; rd_cnt increments; on rd_cnt == L-1 it wraps to 0, full[rd_sel] clears, rd_sel toggles.
REQ-021 Latency: out_valid SHALL rise the cycle after the last byte of a block is accepted.
REQ-022 Throughput: with out_ready held high, one byte per cycle sustained, no bubbles between blocks.
REQ-023 Simultaneous fill of one bank and drain of the other SHALL be supported in the same cycle.
REQ-024 Both banks full: in_ready = 0 until the last byte of the draining bank is emitted; in_ready rises the following cycle.
REQ-025 in_valid while in_ready = 0 SHALL be ignored; no data loss or corruption of stored bytes.
REQ-026 out_ready low SHALL hold out_byte, out_first, out_inv stable while out_valid is high.
REQ-027 in_inv changes at wr_cnt != 0 SHALL NOT affect the block in progress.

Reset
REQ-028 reset SHALL clear full flags, wr_cnt, rd_cnt, wr_sel, rd_sel and mode bits; bank contents are not reset.
REQ-029 Reset values: in_ready = 1, out_valid = 0, out_byte = 8'h00, out_first = 0, out_inv = 0.
REQ-030 Reset mid-block SHALL discard partial and full blocks; the next accepted byte is byte 0 of a new block.

Configuration
REQ-031 Macro SHIFTROWS_INV_EN defined: in_inv selects inverse per REQ-014.
REQ-032 Macro SHIFTROWS_INV_EN undefined: in_inv ignored, forward only, out_inv tied 0, inverse index logic not built.

Verification
REQ-033 NB=4, fwd, input d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> output d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5 (FIPS-197 round 1).
REQ-034 NB=4, inv, input 00..0f -> output 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03, out_inv = 1.
REQ-035 NB=8, fwd, input 00..1f -> first output column 00 05 0e 13; all 32 bytes match REQ-014.
REQ-036 Three back-to-back blocks, out_ready = 1 -> 48 consecutive output bytes with no gaps, out_first on bytes 0/16/32, out_valid one cycle after byte 15 accepted.
REQ-037 Random out_ready stalls, in_valid high -> in_ready drops when both banks full and rises the cycle after the final drain; output stream bit-exact.
REQ-038 reset asserted after 7 bytes of block -> out_valid stays 0; next 16 bytes form a correctly permuted block.
